// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer width convention and gray/binary conversion.
// Used by both the read-side and write-side pointer controllers.
package fifo_pkg;

  localparam int PTR_EXTRA_BITS = 1;

  function automatic int ptr_width(input int addr_width);
    return addr_width + PTR_EXTRA_BITS;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down, done in log2 doubling steps.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int s = 1; s < 32; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray_conv.sv
// Binary-to-gray register stage; one cycle latency, no backpressure.
// Shared by read and write pointer controllers.
module fifo_gray_conv
  import fifo_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] bin_i,
  output logic [W-1:0] gray_q
);

  logic [W-1:0] gray_d;

  always_comb begin
    gray_d = W'(bin2gray(32'(bin_i)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gray_q <= '0;
    end else begin
      gray_q <= gray_d;
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side pointer/EMPTY controller; reads update RADDR/RPTR/EMPTY at the accepting edge.
// RINC is ignored while EMPTY; optional registered fill level under FIFO_RD_LEVEL_EN.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RINC,
  input  logic [ADDR_WIDTH:0]   SYNC_WPTR,
  output logic [ADDR_WIDTH-1:0] RADDR,
  output logic [ADDR_WIDTH:0]   RPTR,
  output logic                  EMPTY
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   RLEVEL
`endif
);

  localparam int PW = ptr_width(ADDR_WIDTH);

  logic          rd_en;
  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rgray_next;
  logic          empty_q, empty_d;

  always_comb begin
    rd_en      = RINC & ~empty_q;
    rbin_d     = rbin_q + PW'(rd_en);
    rgray_next = PW'(bin2gray(32'(rbin_d)));
    // Compare the post-read pointer so the last read empties at the same edge.
    empty_d    = (rgray_next == SYNC_WPTR);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      rbin_q  <= '0;
      empty_q <= 1'b1;
    end else begin
      rbin_q  <= rbin_d;
      empty_q <= empty_d;
    end
  end

  fifo_gray_conv #(.W(PW)) u_rptr_conv (
    .clk    (CLK),
    .rst_n  (RST),
    .bin_i  (rbin_d),
    .gray_q (RPTR)
  );

  assign RADDR = rbin_q[ADDR_WIDTH-1:0];
  assign EMPTY = empty_q;

`ifdef FIFO_RD_LEVEL_EN
  logic [PW-1:0] rlevel_q, rlevel_d;

  always_comb begin
    rlevel_d = PW'(gray2bin(32'(SYNC_WPTR))) - rbin_d;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      rlevel_q <= '0;
    end else begin
      rlevel_q <= rlevel_d;
    end
  end

  assign RLEVEL = rlevel_q;
`endif

endmodule
